// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types.
// Provides the word and cache-block types, the write-buffer FSM state enum,
// and a pointer-width helper used by the buffer storage.
package lc3b_types;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned C_BLOCK_W = 128;

  typedef logic [WORD_W-1:0]    lc3b_word;
  typedef logic [C_BLOCK_W-1:0] lc3b_c_block;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    RESP
  } lc3b_wbuf_state;

  // A single-entry buffer still needs a 1-bit pointer.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wbuf_entry_array.sv
// Write-buffer entry storage: DEPTH FIFO-ordered {valid, tag, block} entries.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (clears valid/pointers)
//   tag              block tag used for lookup and for push
//   push             allocate tag/wdata at tail
//   coalesce         overwrite data of entry coalesce_index with wdata
//   coalesce_index   entry to overwrite
//   wdata            block data for push/coalesce
//   pop              retire the head entry
//   hit_c            some valid entry matches tag
//   hit_index_c      index of the matching entry
//   hit_data_c       data of the matching entry
//   head_tag_c       tag of the head (oldest) entry
//   head_data_c      data of the head entry
//   count            number of valid entries
//   full_c           count == DEPTH
module wbuf_entry_array
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 12,
  localparam int unsigned PTR_W = ptr_width(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAG_W-1:0]  tag,
  input  logic              push,
  input  logic              coalesce,
  input  logic [PTR_W-1:0]  coalesce_index,
  input  logic [127:0]      wdata,
  input  logic              pop,
  output logic              hit_c,
  output logic [PTR_W-1:0]  hit_index_c,
  output logic [127:0]      hit_data_c,
  output logic [TAG_W-1:0]  head_tag_c,
  output logic [127:0]      head_data_c,
  output logic [CNT_W-1:0]  count,
  output logic              full_c
);

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tags  [DEPTH];
  lc3b_c_block      blocks[DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Valid bits, pointers and occupancy; the FSM never pushes and pops together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= ptr_inc(tail);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= ptr_inc(head);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Tag/data payload; qualified by valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      tags[tail]   <= tag;
      blocks[tail] <= wdata;
    end else if (coalesce) begin
      blocks[coalesce_index] <= wdata;
    end
  end

  // Parallel tag compare; tags are unique among valid entries.
  always_comb begin
    hit_c       = 1'b0;
    hit_index_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == tag)) begin
        hit_c       = 1'b1;
        hit_index_c = PTR_W'(i);
      end
    end
  end

  assign hit_data_c  = blocks[hit_index_c];
  assign head_tag_c  = tags[head];
  assign head_data_c = blocks[head];
  assign full_c      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/pmem_write_buffer.sv
// Posted write buffer between the cache arbiter and physical memory.
// Writes are absorbed into a small FIFO and drained to pmem while no read is
// in progress; reads hitting a buffered block are served from the buffer.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   mem_address/read/write/wdata    arbiter request, held until mem_resp
//   mem_rdata, mem_resp             read block and one-cycle completion
//   pmem_address/read/write/wdata   physical memory request, held until pmem_resp
//   pmem_rdata, pmem_resp           physical memory completion
module pmem_write_buffer
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned TAG_W = WORD_W - OFFSET_BITS;
  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  lc3b_wbuf_state   state;
  lc3b_wbuf_state   state_next;

  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic [PTR_W-1:0] hit_index;
  lc3b_c_block      hit_data;
  logic [TAG_W-1:0] head_tag;
  lc3b_c_block      head_data;
  logic [CNT_W-1:0] count;
  logic             full;

  logic             push;
  logic             coalesce;
  logic             pop;
  logic             load_hit;
  logic             load_pmem;

  assign req_tag = mem_address[WORD_W-1:OFFSET_BITS];

  wbuf_entry_array #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_entries (
    .clk            (clk),
    .rst_n          (rst_n),
    .tag            (req_tag),
    .push           (push),
    .coalesce       (coalesce),
    .coalesce_index (hit_index),
    .wdata          (mem_wdata),
    .pop            (pop),
    .hit_c          (hit),
    .hit_index_c    (hit_index),
    .hit_data_c     (hit_data),
    .head_tag_c     (head_tag),
    .head_data_c    (head_data),
    .count          (count),
    .full_c         (full)
  );

  // Next state and buffer control; reads are checked against the buffer first.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    coalesce   = 1'b0;
    pop        = 1'b0;
    load_hit   = 1'b0;
    load_pmem  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read) begin
          if (hit) begin
            load_hit   = 1'b1;
            state_next = RESP;
          end else begin
            state_next = READ;
          end
        end else if (mem_write) begin
          if (hit) begin
            coalesce   = 1'b1;
            state_next = RESP;
          end else if (!full) begin
            push       = 1'b1;
            state_next = RESP;
          end else begin
            state_next = DRAIN;
          end
        end else if (count != '0) begin
          state_next = DRAIN;
        end
      end
      READ: begin
        if (pmem_resp) begin
          load_pmem  = 1'b1;
          state_next = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_rdata    <= '0;
      mem_resp     <= 1'b0;
      pmem_address <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_wdata   <= '0;
    end else begin
      state      <= state_next;
      mem_resp   <= (state_next == RESP);
      pmem_read  <= (state_next == READ);
      pmem_write <= (state_next == DRAIN);
      if (load_hit) begin
        mem_rdata <= hit_data;
      end else if (load_pmem) begin
        mem_rdata <= pmem_rdata;
      end
      // Head cannot change during a drain, so re-loading keeps these stable.
      if (state_next == READ) begin
        pmem_address <= mem_address;
      end else if (state_next == DRAIN) begin
        pmem_address <= {head_tag, {OFFSET_BITS{1'b0}}};
        pmem_wdata   <= head_data;
      end
    end
  end

  // Read and write together is a protocol violation by the requester.
  a_no_read_write: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_read && mem_write));

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Self-checking bench for pmem_write_buffer with a behavioural pmem and a
// "last written value per block" golden memory.
module tb_pmem_write_buffer;

  localparam int unsigned DEPTH       = 2;
  localparam int unsigned OFFSET_BITS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  pmem_write_buffer #(.DEPTH(DEPTH), .OFFSET_BITS(OFFSET_BITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory contents and golden (latest written) contents per block.
  logic [127:0] pm   [logic [15:0]];
  logic [127:0] gold [logic [15:0]];

  function automatic logic [127:0] blk_init(input logic [15:0] a);
    logic [15:0] b;
    b = a & 16'hFFF0;
    return {4{b ^ 16'h5A5A, b}};
  endfunction

  function automatic logic [127:0] pm_get(input logic [15:0] a);
    logic [15:0] k;
    k = a & 16'hFFF0;
    if (pm.exists(k)) return pm[k];
    return blk_init(k);
  endfunction

  function automatic logic [127:0] gold_get(input logic [15:0] a);
    logic [15:0] k;
    k = a & 16'hFFF0;
    if (gold.exists(k)) return gold[k];
    return blk_init(k);
  endfunction

  // Behavioural pmem: responds after pm_delay strobe cycles, logs completed writes.
  int           pm_delay = 2;
  int           wait_cnt = 0;
  bit           in_txn = 1'b0;
  int           pm_read_cycles = 0;
  int           pm_write_cycles = 0;
  int           last_resp_cyc = -10;
  int           stab_err = 0;
  logic [15:0]  hold_addr;
  logic [127:0] hold_wdata;
  logic [15:0]  log_addr[$];
  logic [127:0] log_data[$];
  int           log_cyc[$];

  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (pmem_read || pmem_write) begin
      if (pmem_read) pm_read_cycles++;
      if (pmem_write) pm_write_cycles++;
      if (!in_txn) begin
        in_txn     = 1'b1;
        hold_addr  = pmem_address;
        hold_wdata = pmem_wdata;
        wait_cnt   = 0;
      end else if (pmem_address != hold_addr || (pmem_write && pmem_wdata != hold_wdata)) begin
        stab_err++;
      end
      wait_cnt++;
      if (wait_cnt >= pm_delay) begin
        pmem_resp     = 1'b1;
        last_resp_cyc = cyc;
        in_txn        = 1'b0;
        if (pmem_write) begin
          pm[pmem_address] = pmem_wdata;
          log_addr.push_back(pmem_address);
          log_data.push_back(pmem_wdata);
          log_cyc.push_back(cyc);
        end else begin
          pmem_rdata = pm_get(pmem_address);
        end
      end
    end else begin
      in_txn = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One arbiter transaction; returns read data, edge-count latency and response cycle.
  task automatic do_req(input bit wr, input logic [15:0] addr, input logic [127:0] data,
                        output logic [127:0] rd, output int lat, output int resp_cyc);
    rd          = '0;
    lat         = -1;
    resp_cyc    = -1;
    mem_address = addr;
    mem_wdata   = data;
    mem_write   = wr;
    mem_read    = !wr;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (mem_resp) begin
        lat      = n;
        rd       = mem_rdata;
        resp_cyc = cyc;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL req_timeout: addr %h got no mem_resp within 300 cycles", addr);
    end else begin
      @(posedge clk);
      #1;
      chk("resp_one_cycle", 128'(mem_resp), 128'(0));
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (wr) gold[addr & 16'hFFF0] = data;
  endtask

  typedef struct {
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] data;
    logic [127:0] exp_rd;
    int           exp_lat;     // 0: not checked
    bit           exp_pmem_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    logic [127:0] da, db, dc, dd, de, d1, d2, d3, rd, snap;
    int lat, rc, base, pr0, pw0, se0;

    da = {4{32'hA0A0_1230}};
    db = {4{32'hB0B0_2000}};
    dc = {4{32'hC0C0_2000}};
    dd = {4{32'hD0D0_4000}};
    de = {4{32'hE0E0_5000}};
    d1 = {4{32'h1111_1000}};
    d2 = {4{32'h2222_2000}};
    d3 = {4{32'h3333_3000}};

    vecs[0] = '{1'b1, 16'h1230, da, '0, 1, 1'b0};
    vecs[1] = '{1'b0, 16'h1234, '0, da, 1, 1'b0};
    vecs[2] = '{1'b1, 16'h2000, db, '0, 1, 1'b0};
    vecs[3] = '{1'b1, 16'h2000, dc, '0, 1, 1'b0};
    vecs[4] = '{1'b0, 16'h2008, '0, dc, 1, 1'b0};
    vecs[5] = '{1'b0, 16'h4000, '0, blk_init(16'h4000), 0, 1'b1};
    vecs[6] = '{1'b0, 16'h1230, '0, da, 1, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_resp", 128'(mem_resp), 128'(0));
    chk("rst_mem_rdata", mem_rdata, 128'(0));
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_pmem_address", 128'(pmem_address), 128'(0));
    chk("rst_pmem_wdata", pmem_wdata, 128'(0));
    rst_n = 1'b1;

    // Empty and idle: no pmem traffic
    idle(10);
    chk_int("idle_no_pmem", pm_read_cycles + pm_write_cycles, 0);

    // Table: back-to-back requests, no idle gaps so no drain intervenes
    pm_delay = 2;
    base = log_addr.size();
    foreach (vecs[i]) begin
      pr0 = pm_read_cycles;
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, lat, rc);
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].exp_lat != 0) chk_int($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk_int($sformatf("vec%0d_pmem_read", i), int'(pm_read_cycles > pr0), int'(vecs[i].exp_pmem_rd));
    end
    chk_int("table_no_drain_yet", log_addr.size(), base);

    // Idle drain: A to 0x1230 first, then a single coalesced C to 0x2000
    idle(30);
    chk_int("drain_count", log_addr.size(), base + 2);
    if (log_addr.size() >= base + 2) begin
      chk("drain0_addr", 128'(log_addr[base]), 128'(16'h1230 & 16'hFFF0));
      chk("drain0_data", log_data[base], da);
      chk("drain1_addr", 128'(log_addr[base + 1]), 128'(16'h2000));
      chk("drain1_data", log_data[base + 1], dc);
    end
    pw0 = pm_write_cycles;
    idle(10);
    chk_int("drained_quiet", pm_write_cycles, pw0);

    // Full buffer with a pending write: exactly one drain, then accept
    pm_delay = 5;
    base = log_addr.size();
    do_req(1'b1, 16'h1000, d1, rd, lat, rc);
    chk_int("full_w1_latency", lat, 1);
    do_req(1'b1, 16'h2000, d2, rd, lat, rc);
    chk_int("full_w2_latency", lat, 1);
    do_req(1'b1, 16'h3000, d3, rd, lat, rc);
    chk_int("full_w3_one_drain", log_addr.size(), base + 1);
    if (log_addr.size() > base) begin
      chk("full_first_drain_addr", 128'(log_addr[base]), 128'(16'h1000));
      chk_int("full_w3_after_drain", int'(rc > log_cyc[base]), 1);
    end
    idle(60);
    chk_int("full_drain_count", log_addr.size(), base + 3);
    if (log_addr.size() >= base + 3) begin
      chk("full_drain1_addr", 128'(log_addr[base + 1]), 128'(16'h2000));
      chk("full_drain1_data", log_data[base + 1], d2);
      chk("full_drain2_addr", 128'(log_addr[base + 2]), 128'(16'h3000));
      chk("full_drain2_data", log_data[base + 2], d3);
    end

    // Read miss: data and response one cycle after pmem_resp, address held
    pm_delay = 3;
    pm[16'h4000]   = dd;
    gold[16'h4000] = dd;
    se0 = stab_err;
    do_req(1'b0, 16'h4000, '0, rd, lat, rc);
    chk("miss_rdata", rd, dd);
    chk_int("miss_resp_cycle", rc, last_resp_cyc + 1);
    chk_int("miss_addr_stable", stab_err, se0);

    // Randomised traffic against the golden memory
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      bit w;
      a = 16'((($urandom_range(1, 6)) << 12) | ($urandom_range(0, 15) & 32'hE));
      w = ($urandom_range(0, 1) == 1);
      pm_delay = $urandom_range(1, 4);
      do_req(w, a, {$urandom, $urandom, $urandom, $urandom}, rd, lat, rc);
      if (!w) chk($sformatf("rand%0d_rdata_%h", n, a), rd, gold_get(a));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
    idle(100);
    foreach (gold[k]) chk($sformatf("final_mem_%h", k), pm_get(k), gold[k]);
    chk_int("addr_stable_overall", stab_err, 0);

    // Reset mid-drain abandons buffered data
    pm_delay = 20;
    snap = pm_get(16'h5000);
    do_req(1'b1, 16'h5000, de, rd, lat, rc);
    for (int n = 0; n < 20 && !pmem_write; n++) idle(1);
    chk("drain_started", 128'(pmem_write), 128'(1));
    idle(2);
    rst_n = 1'b0;
    idle(1);
    chk("rst_drain_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_drain_mem_resp", 128'(mem_resp), 128'(0));
    chk("rst_drain_pmem_read", 128'(pmem_read), 128'(0));
    rst_n = 1'b1;
    pw0 = pm_write_cycles;
    idle(10);
    chk_int("rst_buffer_empty", pm_write_cycles, pw0);
    pm_delay = 2;
    pr0 = pm_read_cycles;
    do_req(1'b0, 16'h5000, '0, rd, lat, rc);
    chk_int("rst_read_goes_to_pmem", int'(pm_read_cycles > pr0), 1);
    chk("rst_read_data", rd, snap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmem_write_buffer.md
Name: pmem_write_buffer

Overview:
- Posted write buffer between the I/D-cache arbiter and physical memory.
- Absorbs dirty-block writebacks so the requesting cache resumes after one cycle.
- Drains buffered blocks to pmem when no read is in progress.
- Serves read hits from buffered blocks so no read ever returns stale memory data.

Parameters:
DEPTH, 2, number of buffered block entries (power of two, >=1)
OFFSET_BITS, 4, byte-offset bits within a 16-byte block; address[15:OFFSET_BITS] is the block tag

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
mem_address  input  16  block address from arbiter (lc3b_word)
mem_read  input  1  read request, held until mem_resp
mem_write  input  1  write request, held until mem_resp
mem_wdata  input  128  write block (lc3b_c_block)
mem_rdata  output  128  read block, valid while mem_resp=1
mem_resp  output  1  one-cycle completion pulse
pmem_address  output  16  physical memory address
pmem_read  output  1  physical read strobe
pmem_write  output  1  physical write strobe
pmem_wdata  output  128  physical write block
pmem_rdata  input  128  physical read block
pmem_resp  input  1  physical completion

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values:
  - All entry valid bits cleared; state IDLE.
  - All outputs 0.
  - Reset during READ or DRAIN abandons the transaction; buffered data is lost.
- Storage:
  - DEPTH entries of {valid, tag, 128-bit data}, kept in FIFO order with head/tail pointers.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Hit rule: an entry hits when it is valid and its tag equals mem_address[15:OFFSET_BITS]. At most one entry can hit.
- FSM states: IDLE, READ, DRAIN, RESP.
- IDLE, priority order:
  1. mem_read with a buffer hit -> latch the entry data into mem_rdata, go to RESP. No pmem access.
  2. mem_read with a miss -> go to READ.
  3. mem_write hitting an entry that is not the draining head -> overwrite that entry's data (coalesce), go to RESP.
  4. mem_write with a miss and count<DEPTH -> write at tail, tail++, go to RESP.
  5. mem_write while full, or any count>0 with no request -> go to DRAIN.
- READ:
  - pmem_read=1 and pmem_address=mem_address, held.
  - On pmem_resp, register pmem_rdata into mem_rdata and go to RESP.
- DRAIN:
  - pmem_write=1, pmem_address={head tag, OFFSET_BITS'b0}, pmem_wdata=head data, all held stable.
  - On pmem_resp, clear the head valid bit, head++, count--, go to IDLE.
  - A started drain always completes; incoming requests wait.
- RESP: mem_resp=1 for exactly one cycle, then IDLE. The requester drops its request on the edge that ends RESP.
- Latency:
  - Buffered write or read hit: mem_resp in the 2nd cycle after the request is seen in IDLE.
  - Read miss: mem_resp in the cycle after pmem_resp.
- Ordering and boundary cases:
  - A read miss never bypasses a matching entry, because the hit check precedes the pmem read.
  - A write to the tag of the entry currently draining cannot occur, since requests are only accepted in IDLE.
  - Full with a pending write: exactly one drain, then the write is accepted.
  - Empty and idle: no pmem activity.
  - mem_read and mem_write asserted together is illegal; it is covered by an assertion.
- Arithmetic: count has width $clog2(DEPTH+1); pointers have width $clog2(DEPTH), with a minimum of 1.

Decomposition:
- Add to lc3b_types: lc3b_wbuf_state enum {IDLE, READ, DRAIN, RESP}.
- Reuse the existing lc3b_word and lc3b_c_block types from lc3b_types.
- One sub-module, wbuf_entry_array, containing:
  - valid/tag/data storage and head/tail/count;
  - the parallel tag compare (hit, hit_index);
  - the write/coalesce/pop ports.
- The FSM and pmem muxing stay in pmem_write_buffer.

Test Plan:
- Write 0x1230 with data A while empty -> mem_resp pulse 2 cycles later, no pmem_write that cycle, count=1. With no further requests, exactly one pmem_write to 0x1230 with data A; count=0 after pmem_resp.
- Write 0x1230 (A), then read 0x1234 -> mem_rdata=A with mem_resp, pmem_read never asserted.
- Write 0x2000 (B), then write 0x2000 (C) before the drain starts -> single pmem_write of C; count peaks at 1.
- DEPTH=2: writes to 0x1000, 0x2000, 0x3000 back-to-back with pmem_resp delayed 5 cycles -> third write's mem_resp only after the 0x1000 drain completes. Drain order is 0x1000 then 0x2000, then 0x3000.
- Read miss 0x4000 with pmem_rdata=D and pmem_resp after 3 cycles -> mem_rdata=D with mem_resp in the following cycle; pmem_address held at 0x4000 throughout.
- rst_n=0 asserted mid-DRAIN -> next cycle pmem_write=0, mem_resp=0, count=0, state IDLE. A subsequent read of the abandoned tag goes to pmem.
